// File: rtl/eth_hdr_parser_if.sv
// Inbound frame, parsed header and realigned payload channels of the Ethernet RX header parser.
// master = parser side, slave = MAC RX FIFO / receive demux side.
interface eth_hdr_parser_if;
  logic         eth_rx_data_val;
  logic [63:0]  eth_rx_data;
  logic         eth_rx_data_last;
  logic [2:0]   eth_rx_data_padbytes;
  logic         eth_rx_data_rdy;

  logic         inbound_eth_hdr_val;
  logic [111:0] inbound_eth_hdr;
  logic         inbound_eth_hdr_rdy;

  logic         eth_payload_val;
  logic [63:0]  eth_payload_data;
  logic         eth_payload_last;
  logic [2:0]   eth_payload_padbytes;
  logic         eth_payload_rdy;

  modport master (
    input  eth_rx_data_val, eth_rx_data, eth_rx_data_last, eth_rx_data_padbytes,
    output eth_rx_data_rdy,
    output inbound_eth_hdr_val, inbound_eth_hdr,
    input  inbound_eth_hdr_rdy,
    output eth_payload_val, eth_payload_data, eth_payload_last, eth_payload_padbytes,
    input  eth_payload_rdy
  );

  modport slave (
    output eth_rx_data_val, eth_rx_data, eth_rx_data_last, eth_rx_data_padbytes,
    input  eth_rx_data_rdy,
    input  inbound_eth_hdr_val, inbound_eth_hdr,
    output inbound_eth_hdr_rdy,
    input  eth_payload_val, eth_payload_data, eth_payload_last, eth_payload_padbytes,
    output eth_payload_rdy
  );
endinterface

// File: rtl/eth_hdr_parser.sv
// Strips the 14-byte Ethernet header from a 64-bit RX stream and realigns the payload.
// Optional destination-MAC filter enabled by defining ETH_RX_MAC_FILTER_EN.
package eth_hdr_parser_pkg;
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] eth_type;
  } eth_hdr_t;
endpackage

module eth_hdr_parser
  import eth_hdr_parser_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  eth_hdr_parser_if.master bus,
  output logic [CNT_W-1:0] runt_frame_cnt,
  output logic [CNT_W-1:0] filtered_frame_cnt
);

  typedef enum logic [2:0] {HDR0, HDR1, HDR_OUT, PAYLOAD, FLUSH, DRAIN} state_t;

  state_t      state, state_nxt;
  eth_hdr_t    hdr_q;
  logic [15:0] carry_q;
  logic [2:0]  pad_q;

  logic        rx_rdy_c;
  logic        hdr_val_c;
  logic        pay_val_c;
  logic [63:0] pay_data_c;
  logic        pay_last_c;
  logic [2:0]  pay_pad_c;
  logic        rx_hs_c;
  logic        filt_match_c;
  logic        runt_hit_c;
  logic        filt_hit_c;

`ifdef ETH_RX_MAC_FILTER_EN
  assign filt_match_c = (hdr_q.dst != LOCAL_MAC) && (hdr_q.dst != 48'hFFFF_FFFF_FFFF);
`else
  logic unused_local_mac;
  assign unused_local_mac = ^LOCAL_MAC;
  assign filt_match_c     = 1'b0;
`endif

  assign rx_hs_c    = bus.eth_rx_data_val && rx_rdy_c;
  assign runt_hit_c = rx_hs_c && bus.eth_rx_data_last && (state == HDR0 || state == HDR1);
  assign filt_hit_c = rx_hs_c && !bus.eth_rx_data_last && (state == HDR1) && filt_match_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR0;
    else     state <= state_nxt;
  end

  // Next state and channel outputs
  always_comb begin
    state_nxt  = state;
    rx_rdy_c   = 1'b0;
    hdr_val_c  = 1'b0;
    pay_val_c  = 1'b0;
    pay_data_c = 64'h0;
    pay_last_c = 1'b0;
    pay_pad_c  = 3'd0;
    case (state)
      HDR0: begin
        rx_rdy_c = 1'b1;
        if (bus.eth_rx_data_val && !bus.eth_rx_data_last) state_nxt = HDR1;
      end
      HDR1: begin
        rx_rdy_c = 1'b1;
        if (bus.eth_rx_data_val) begin
          if (bus.eth_rx_data_last) state_nxt = HDR0;
          else if (filt_match_c)    state_nxt = DRAIN;
          else                      state_nxt = HDR_OUT;
        end
      end
      HDR_OUT: begin
        hdr_val_c = 1'b1;
        if (bus.inbound_eth_hdr_rdy) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        rx_rdy_c   = bus.eth_payload_rdy;
        pay_val_c  = bus.eth_rx_data_val;
        pay_data_c = {carry_q, bus.eth_rx_data[63:16]};
        // Fewer than two pad bytes leaves tail bytes in carry that need a flush beat
        if (bus.eth_rx_data_last && bus.eth_rx_data_padbytes >= 3'd2) begin
          pay_last_c = 1'b1;
          pay_pad_c  = bus.eth_rx_data_padbytes - 3'd2;
        end
        if (rx_hs_c && bus.eth_rx_data_last)
          state_nxt = (bus.eth_rx_data_padbytes >= 3'd2) ? HDR0 : FLUSH;
      end
      FLUSH: begin
        pay_val_c  = 1'b1;
        pay_data_c = {carry_q, 48'h0};
        pay_last_c = 1'b1;
        pay_pad_c  = 3'd6 + pad_q;
        if (bus.eth_payload_rdy) state_nxt = HDR0;
      end
      DRAIN: begin
        rx_rdy_c = 1'b1;
        if (bus.eth_rx_data_val && bus.eth_rx_data_last) state_nxt = HDR0;
      end
      default: state_nxt = HDR0;
    endcase
  end

  // Header capture, payload carry and runt statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_q          <= '0;
      carry_q        <= 16'h0;
      pad_q          <= 3'd0;
      runt_frame_cnt <= '0;
    end else begin
      if (rx_hs_c) begin
        case (state)
          HDR0: begin
            hdr_q.dst          <= bus.eth_rx_data[63:16];
            hdr_q.src[47:32]   <= bus.eth_rx_data[15:0];
          end
          HDR1: begin
            hdr_q.src[31:0]    <= bus.eth_rx_data[63:32];
            hdr_q.eth_type     <= bus.eth_rx_data[31:16];
            carry_q            <= bus.eth_rx_data[15:0];
          end
          PAYLOAD: begin
            carry_q <= bus.eth_rx_data[15:0];
            if (bus.eth_rx_data_last) pad_q <= bus.eth_rx_data_padbytes;
          end
          default: ;
        endcase
      end
      if (runt_hit_c && runt_frame_cnt != '1)
        runt_frame_cnt <= runt_frame_cnt + CNT_W'(1);
    end
  end

`ifdef ETH_RX_MAC_FILTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) filtered_frame_cnt <= '0;
    else if (filt_hit_c && filtered_frame_cnt != '1)
      filtered_frame_cnt <= filtered_frame_cnt + CNT_W'(1);
  end
`else
  logic unused_filt_hit;
  assign unused_filt_hit    = filt_hit_c;
  assign filtered_frame_cnt = '0;
`endif

  // Ready is withheld while reset is asserted so nothing is accepted mid-reset
  assign bus.eth_rx_data_rdy      = rx_rdy_c && !rst;
  assign bus.inbound_eth_hdr_val  = hdr_val_c;
  assign bus.inbound_eth_hdr      = hdr_q;
  assign bus.eth_payload_val      = pay_val_c;
  assign bus.eth_payload_data     = pay_data_c;
  assign bus.eth_payload_last     = pay_last_c;
  assign bus.eth_payload_padbytes = pay_pad_c;

endmodule

// File: tb/tb_eth_hdr_parser.sv
// Directed self-checking bench for eth_hdr_parser; filter cases follow ETH_RX_MAC_FILTER_EN.
module tb_eth_hdr_parser;
  localparam logic [47:0] LOCAL   = 48'h0200_0000_0001;
  localparam logic [47:0] FOREIGN = 48'h0200_0000_0099;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC     = 48'h0A0B_0C0D_0E0F;
  localparam logic [63:0] B1      = {32'h0C0D_0E0F, 16'h0800, 16'hAABB};
  localparam logic [63:0] B2      = 64'h1122_3344_5566_7788;
  localparam logic [63:0] B3      = 64'h99AA_BBCC_DDEE_FF00;
  localparam logic [63:0] B4      = 64'h0102_0304_0506_0708;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] runt_cnt, filt_cnt;
  int tests = 0;
  int fails = 0;

  eth_hdr_parser_if bus();

  eth_hdr_parser #(.LOCAL_MAC(LOCAL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .runt_frame_cnt(runt_cnt), .filtered_frame_cnt(filt_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l, input logic [2:0] p);
    bus.eth_rx_data_val      = v;
    bus.eth_rx_data          = d;
    bus.eth_rx_data_last     = l;
    bus.eth_rx_data_padbytes = p;
  endtask

  // Drives the two header beats; returns at the negedge where the header should be offered
  task automatic send_hdr(input logic [47:0] dst);
    tick(); drive(1'b1, {dst, SRC[47:32]}, 1'b0, 3'd0);
    tick(); drive(1'b1, B1, 1'b0, 3'd0);
    tick(); drive(1'b0, 64'h0, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    tick(); tick(); #1;
    tests++; if (bus.eth_rx_data_rdy !== 1'b0) begin fails++; $display("FAIL rst_rx_rdy got %b exp 0", bus.eth_rx_data_rdy); end
    tests++; if (bus.inbound_eth_hdr_val !== 1'b0 || bus.eth_payload_val !== 1'b0) begin fails++; $display("FAIL rst_valids got %b%b exp 00", bus.inbound_eth_hdr_val, bus.eth_payload_val); end
    tests++; if (runt_cnt !== 16'd0 || filt_cnt !== 16'd0) begin fails++; $display("FAIL rst_counters got %h/%h exp 0/0", runt_cnt, filt_cnt); end
    tick(); rst = 1'b0; #1;
    tests++; if (bus.eth_rx_data_rdy !== 1'b1) begin fails++; $display("FAIL post_rst_rdy got %b exp 1", bus.eth_rx_data_rdy); end
  endtask

  task automatic test_basic();
    send_hdr(LOCAL);
    bus.inbound_eth_hdr_rdy = 1'b1; #1;
    tests++; if (bus.inbound_eth_hdr_val !== 1'b1) begin fails++; $display("FAIL basic_hdr_val got %b exp 1", bus.inbound_eth_hdr_val); end
    tests++; if (bus.inbound_eth_hdr !== {LOCAL, SRC, 16'h0800}) begin fails++; $display("FAIL basic_hdr got %h exp %h", bus.inbound_eth_hdr, {LOCAL, SRC, 16'h0800}); end
    tests++; if (bus.eth_rx_data_rdy !== 1'b0) begin fails++; $display("FAIL basic_hdrout_rdy got %b exp 0", bus.eth_rx_data_rdy); end
    tick(); bus.inbound_eth_hdr_rdy = 1'b0; bus.eth_payload_rdy = 1'b1; drive(1'b1, B2, 1'b1, 3'd0); #1;
    tests++; if (bus.eth_payload_val !== 1'b1 || bus.eth_payload_data !== 64'hAABB_1122_3344_5566 || bus.eth_payload_last !== 1'b0) begin fails++; $display("FAIL basic_pay0 got %b %h %b exp 1 aabb112233445566 0", bus.eth_payload_val, bus.eth_payload_data, bus.eth_payload_last); end
    tick(); drive(1'b0, 64'h0, 1'b0, 3'd0); #1;
    tests++; if (bus.eth_payload_val !== 1'b1 || bus.eth_payload_data !== 64'h7788_0000_0000_0000 || bus.eth_payload_last !== 1'b1 || bus.eth_payload_padbytes !== 3'd6) begin fails++; $display("FAIL basic_flush got %b %h %b %0d exp 1 7788000000000000 1 6", bus.eth_payload_val, bus.eth_payload_data, bus.eth_payload_last, bus.eth_payload_padbytes); end
    tests++; if (bus.eth_rx_data_rdy !== 1'b0) begin fails++; $display("FAIL basic_flush_rdy got %b exp 0", bus.eth_rx_data_rdy); end
    tick(); #1;
    tests++; if (bus.eth_payload_val !== 1'b0 || bus.eth_rx_data_rdy !== 1'b1) begin fails++; $display("FAIL basic_idle got %b %b exp 0 1", bus.eth_payload_val, bus.eth_rx_data_rdy); end
  endtask

  task automatic test_pad4();
    send_hdr(LOCAL);
    bus.inbound_eth_hdr_rdy = 1'b1;
    tick(); bus.inbound_eth_hdr_rdy = 1'b0; drive(1'b1, B2, 1'b1, 3'd4); #1;
    tests++; if (bus.eth_payload_data[63:16] !== 48'hAABB_1122_3344 || bus.eth_payload_last !== 1'b1 || bus.eth_payload_padbytes !== 3'd2) begin fails++; $display("FAIL pad4_beat got %h %b %0d exp aabb11223344xxxx 1 2", bus.eth_payload_data, bus.eth_payload_last, bus.eth_payload_padbytes); end
    tick(); drive(1'b0, 64'h0, 1'b0, 3'd0); #1;
    tests++; if (bus.eth_payload_val !== 1'b0 || bus.eth_rx_data_rdy !== 1'b1) begin fails++; $display("FAIL pad4_no_flush got %b %b exp 0 1", bus.eth_payload_val, bus.eth_rx_data_rdy); end
  endtask

  task automatic test_runt();
    tick(); drive(1'b1, {LOCAL, SRC[47:32]}, 1'b0, 3'd0);
    tick(); drive(1'b1, B1, 1'b1, 3'd0);
    tick(); drive(1'b1, {LOCAL, SRC[47:32]}, 1'b0, 3'd0); #1;
    tests++; if (bus.inbound_eth_hdr_val !== 1'b0 || bus.eth_payload_val !== 1'b0) begin fails++; $display("FAIL runt_no_out got %b %b exp 0 0", bus.inbound_eth_hdr_val, bus.eth_payload_val); end
    tests++; if (runt_cnt !== 16'd1) begin fails++; $display("FAIL runt_cnt1 got %0d exp 1", runt_cnt); end
    tick(); drive(1'b1, B1, 1'b0, 3'd0);
    tick(); drive(1'b0, 64'h0, 1'b0, 3'd0); bus.inbound_eth_hdr_rdy = 1'b1; #1;
    tests++; if (bus.inbound_eth_hdr_val !== 1'b1 || bus.inbound_eth_hdr !== {LOCAL, SRC, 16'h0800}) begin fails++; $display("FAIL b2b_hdr got %b %h exp 1 %h", bus.inbound_eth_hdr_val, bus.inbound_eth_hdr, {LOCAL, SRC, 16'h0800}); end
    tick(); bus.inbound_eth_hdr_rdy = 1'b0; drive(1'b1, B2, 1'b1, 3'd2); #1;
    tests++; if (bus.eth_payload_data !== 64'hAABB_1122_3344_5566 || bus.eth_payload_last !== 1'b1 || bus.eth_payload_padbytes !== 3'd0) begin fails++; $display("FAIL b2b_pay got %h %b %0d exp aabb112233445566 1 0", bus.eth_payload_data, bus.eth_payload_last, bus.eth_payload_padbytes); end
    tick(); drive(1'b1, {LOCAL, SRC[47:32]}, 1'b1, 3'd0);
    tick(); drive(1'b0, 64'h0, 1'b0, 3'd0); #1;
    tests++; if (runt_cnt !== 16'd2 || bus.inbound_eth_hdr_val !== 1'b0) begin fails++; $display("FAIL runt_beat0 got %0d %b exp 2 0", runt_cnt, bus.inbound_eth_hdr_val); end
  endtask

  task automatic test_filter();
`ifdef ETH_RX_MAC_FILTER_EN
    send_hdr(FOREIGN); #1;
    tests++; if (bus.inbound_eth_hdr_val !== 1'b0 || bus.eth_rx_data_rdy !== 1'b1) begin fails++; $display("FAIL filt_drain got %b %b exp 0 1", bus.inbound_eth_hdr_val, bus.eth_rx_data_rdy); end
    tests++; if (filt_cnt !== 16'd1) begin fails++; $display("FAIL filt_cnt got %0d exp 1", filt_cnt); end
    tick(); drive(1'b1, B2, 1'b0, 3'd0); #1;
    tests++; if (bus.eth_payload_val !== 1'b0) begin fails++; $display("FAIL filt_no_pay got %b exp 0", bus.eth_payload_val); end
    tick(); drive(1'b1, B3, 1'b1, 3'd0);
    tick(); drive(1'b0, 64'h0, 1'b0, 3'd0);
    send_hdr(BCAST); bus.inbound_eth_hdr_rdy = 1'b1; #1;
    tests++; if (bus.inbound_eth_hdr_val !== 1'b1 || bus.inbound_eth_hdr !== {BCAST, SRC, 16'h0800}) begin fails++; $display("FAIL filt_bcast got %b %h exp 1 %h", bus.inbound_eth_hdr_val, bus.inbound_eth_hdr, {BCAST, SRC, 16'h0800}); end
`else
    send_hdr(FOREIGN); bus.inbound_eth_hdr_rdy = 1'b1; #1;
    tests++; if (bus.inbound_eth_hdr_val !== 1'b1 || bus.inbound_eth_hdr !== {FOREIGN, SRC, 16'h0800}) begin fails++; $display("FAIL nofilt_hdr got %b %h exp 1 %h", bus.inbound_eth_hdr_val, bus.inbound_eth_hdr, {FOREIGN, SRC, 16'h0800}); end
    tests++; if (filt_cnt !== 16'd0) begin fails++; $display("FAIL nofilt_cnt got %0d exp 0", filt_cnt); end
`endif
    tick(); bus.inbound_eth_hdr_rdy = 1'b0; drive(1'b1, B2, 1'b1, 3'd2);
    tick(); drive(1'b0, 64'h0, 1'b0, 3'd0);
  endtask

  task automatic test_backpressure();
    logic [63:0] ins [3];
    logic [63:0] exp [3];
    ins[0] = B2; ins[1] = B3; ins[2] = B4;
    exp[0] = 64'hAABB_1122_3344_5566;
    exp[1] = 64'h7788_99AA_BBCC_DDEE;
    exp[2] = 64'hFF00_0102_0304_0506;
    send_hdr(LOCAL);
    drive(1'b1, B2, 1'b0, 3'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (bus.inbound_eth_hdr_val !== 1'b1 || bus.eth_rx_data_rdy !== 1'b0 || bus.eth_payload_val !== 1'b0) begin fails++; $display("FAIL bp_hdr_stall%0d got %b %b %b exp 1 0 0", c, bus.inbound_eth_hdr_val, bus.eth_rx_data_rdy, bus.eth_payload_val); end
      tests++; if (bus.inbound_eth_hdr !== {LOCAL, SRC, 16'h0800}) begin fails++; $display("FAIL bp_hdr_stable%0d got %h exp %h", c, bus.inbound_eth_hdr, {LOCAL, SRC, 16'h0800}); end
      tick();
    end
    bus.inbound_eth_hdr_rdy = 1'b1;
    tick(); bus.inbound_eth_hdr_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 2; r++) begin
        drive(1'b1, ins[i], i == 2, (i == 2) ? 3'd3 : 3'd0);
        bus.eth_payload_rdy = (r == 1); #1;
        tests++; if (bus.eth_payload_val !== 1'b1 || bus.eth_payload_data !== exp[i] || bus.eth_rx_data_rdy !== (r == 1)) begin fails++; $display("FAIL bp_beat%0d_r%0d got %b %h %b exp 1 %h %b", i, r, bus.eth_payload_val, bus.eth_payload_data, bus.eth_rx_data_rdy, exp[i], r == 1); end
        tests++; if (bus.eth_payload_last !== (i == 2) || (i == 2 && bus.eth_payload_padbytes !== 3'd1)) begin fails++; $display("FAIL bp_last%0d_r%0d got %b %0d exp %b 1", i, r, bus.eth_payload_last, bus.eth_payload_padbytes, i == 2); end
        tick();
      end
    end
    drive(1'b0, 64'h0, 1'b0, 3'd0); bus.eth_payload_rdy = 1'b1; #1;
    tests++; if (bus.eth_payload_val !== 1'b0 || bus.eth_rx_data_rdy !== 1'b1) begin fails++; $display("FAIL bp_end got %b %b exp 0 1", bus.eth_payload_val, bus.eth_rx_data_rdy); end
  endtask

  task automatic test_reset_midframe();
    send_hdr(LOCAL); bus.inbound_eth_hdr_rdy = 1'b1;
    tick(); bus.inbound_eth_hdr_rdy = 1'b0; drive(1'b1, B2, 1'b0, 3'd0);
    tick(); drive(1'b1, B3, 1'b0, 3'd0); #1;
    tests++; if (bus.eth_payload_val !== 1'b1) begin fails++; $display("FAIL mid_in_payload got %b exp 1", bus.eth_payload_val); end
    rst = 1'b1; #1;
    tests++; if (bus.eth_payload_val !== 1'b0 || bus.inbound_eth_hdr_val !== 1'b0 || bus.eth_rx_data_rdy !== 1'b0) begin fails++; $display("FAIL mid_rst_valids got %b %b %b exp 0 0 0", bus.eth_payload_val, bus.inbound_eth_hdr_val, bus.eth_rx_data_rdy); end
    tests++; if (runt_cnt !== 16'd0) begin fails++; $display("FAIL mid_rst_cnt got %0d exp 0", runt_cnt); end
    tick(); rst = 1'b0; drive(1'b0, 64'h0, 1'b0, 3'd0);
    send_hdr(48'h0A1B_2C3D_4E5F); #1;
    tests++; if (bus.inbound_eth_hdr_val !== 1'b1 || bus.inbound_eth_hdr !== {48'h0A1B_2C3D_4E5F, SRC, 16'h0800}) begin fails++; $display("FAIL mid_new_hdr got %b %h exp 1 %h", bus.inbound_eth_hdr_val, bus.inbound_eth_hdr, {48'h0A1B_2C3D_4E5F, SRC, 16'h0800}); end
  endtask

  initial begin
    drive(1'b0, 64'h0, 1'b0, 3'd0);
    bus.inbound_eth_hdr_rdy = 1'b0;
    bus.eth_payload_rdy     = 1'b1;
    test_reset();
    test_basic();
    test_pad4();
    test_runt();
    test_filter();
    test_backpressure();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
